// File: rtl/cmp_sar_search.sv
// Successive-approximation search that recovers the value on a magnitude
// comparator's A inputs by driving B and reading the GT/LT/EQ flags.
module cmp_sar_search #(
   parameter int N      = 4,
   parameter int SETTLE = 2,
   parameter int CW     = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          a_gt_b,
   input  logic          a_lt_b,
   input  logic          a_eq_b,
   output logic [N-1:0]  b_out,
   output logic          busy,
   output logic          done,
   output logic          found,
   output logic [N-1:0]  result,
   output logic          err,
   output logic [CW-1:0] probes
);

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0] CNT_INIT = SW'(SETTLE - 1);
   localparam logic [N:0]    HI_INIT  = {1'b0, {N{1'b1}}};
   localparam logic [N-1:0]  B_INIT   = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DECIDE, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [N:0]      lo_q, lo_d, hi_q, hi_d;
   logic [N-1:0]    b_q, b_d, result_q, result_d;
   logic [SW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   probes_q, probes_d;
   logic            found_q, found_d, err_q, err_d;

   logic            onehot_w, empty_w;
   logic [N:0]      lo_n, hi_n;
   logic [N-1:0]    mid_w;

   // Midpoint rounds up so the first probe lands on 2^(N-1).
   function automatic logic [N-1:0] mid_of(input logic [N:0] lo, input logic [N:0] hi);
      logic [N+1:0] s;
      s = {1'b0, lo} + {1'b0, hi} + (N+2)'(1);
      return s[N:1];
   endfunction

   // lo is unsigned (may reach 2^N), hi is signed (may reach -1).
   function automatic logic range_empty(input logic [N:0] lo, input logic [N:0] hi);
      return $signed({1'b0, lo}) > $signed({hi[N], hi});
   endfunction

   always_comb begin
      onehot_w = ({a_gt_b, a_lt_b, a_eq_b} == 3'b100) ||
                 ({a_gt_b, a_lt_b, a_eq_b} == 3'b010) ||
                 ({a_gt_b, a_lt_b, a_eq_b} == 3'b001);
      lo_n = lo_q;
      hi_n = hi_q;
      if (a_gt_b)
         lo_n = {1'b0, b_q} + (N+1)'(1);
      else if (a_lt_b)
         hi_n = {1'b0, b_q} - (N+1)'(1);
      empty_w = range_empty(lo_n, hi_n);
      mid_w   = mid_of(lo_n, hi_n);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_SETTLE;
         S_SETTLE: if (cnt_q == '0) state_d = S_DECIDE;
         S_DECIDE: begin
            if (!onehot_w || a_eq_b || empty_w)
               state_d = S_DONE;
            else
               state_d = S_SETTLE;
         end
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         S_SETTLE, S_DECIDE: busy = 1'b1;
         S_DONE:             done = 1'b1;
         default:            ;
      endcase
   end

   always_comb begin
      lo_d     = lo_q;
      hi_d     = hi_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      probes_d = probes_q;
      found_d  = found_q;
      err_d    = err_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               lo_d     = '0;
               hi_d     = HI_INIT;
               b_d      = B_INIT;
               cnt_d    = CNT_INIT;
               probes_d = '0;
               err_d    = 1'b0;
               found_d  = 1'b0;
            end
         end
         S_SETTLE: if (cnt_q != '0) cnt_d = cnt_q - SW'(1);
         S_DECIDE: begin
            probes_d = probes_q + CW'(1);
            if (!onehot_w) begin
               err_d   = 1'b1;
               found_d = 1'b0;
            end else if (a_eq_b) begin
               result_d = b_q;
               found_d  = 1'b1;
            end else begin
               lo_d = lo_n;
               hi_d = hi_n;
               if (empty_w) begin
                  err_d   = 1'b1;
                  found_d = 1'b0;
               end else begin
                  b_d   = mid_w;
                  cnt_d = CNT_INIT;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lo_q     <= '0;
         hi_q     <= HI_INIT;
         b_q      <= '0;
         cnt_q    <= '0;
         probes_q <= '0;
         found_q  <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
      end else begin
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         probes_q <= probes_d;
         found_q  <= found_d;
         err_q    <= err_d;
         result_q <= result_d;
      end
   end

   assign b_out  = b_q;
   assign found  = found_q;
   assign result = result_q;
   assign err    = err_q;
   assign probes = probes_q;

endmodule

// File: tb/tb_cmp_sar_search.sv
// Directed bench for cmp_sar_search: table of searches against a behavioural
// comparator, plus hand-written reset-abort sequence.
module tb_cmp_sar_search;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       a_gt_b, a_lt_b, a_eq_b;
   logic [3:0] b_out;
   logic       busy, done, found, err;
   logic [3:0] result;
   logic [2:0] probes;

   // 0 = healthy comparator, 1 = GT and LT both high, 2 = always GT
   int         mode;
   logic [3:0] a_val;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign a_gt_b = (mode != 0) ? 1'b1 : (a_val > b_out);
   assign a_lt_b = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (a_val < b_out);
   assign a_eq_b = (mode == 0) && (a_val == b_out);

   cmp_sar_search #(.N(4), .SETTLE(2), .CW(3)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a_gt_b (a_gt_b),
      .a_lt_b (a_lt_b),
      .a_eq_b (a_eq_b),
      .b_out  (b_out),
      .busy   (busy),
      .done   (done),
      .found  (found),
      .result (result),
      .err    (err),
      .probes (probes)
   );

   typedef struct {
      int         mode;
      logic [3:0] a;
      bit         pulse;
      logic       exp_found;
      logic       exp_err;
      int         exp_probes;
      logic [3:0] exp_result;
      bit         chk_seq;
      int         exp_seq;
      int         exp_len;
   } vec_t;

   vec_t vecs[$];

   int         seq_q[$];
   int         n_done, done_cyc;
   logic       f_cap, e_cap;
   logic [3:0] r_cap;
   logic [2:0] p_cap;
   logic       busy_after;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int m, input int a, input bit pulse, input logic f,
                               input logic e, input int p, input int r, input bit cs,
                               input int s, input int l);
      vec_t v;
      v.mode = m; v.a = 4'(a); v.pulse = pulse; v.exp_found = f; v.exp_err = e;
      v.exp_probes = p; v.exp_result = 4'(r); v.chk_seq = cs; v.exp_seq = s; v.exp_len = l;
      return v;
   endfunction

   // Cycle c is the c-th clock period after the start-accept edge.
   task automatic do_search(input bit pulse);
      seq_q.delete();
      n_done = 0; done_cyc = -1; busy_after = 1'b0;
      f_cap = 1'bx; e_cap = 1'bx; r_cap = 'x; p_cap = 'x;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (busy && (seq_q.size() == 0 || seq_q[$] != int'(b_out)))
            seq_q.push_back(int'(b_out));
         if (done) begin
            n_done++;
            if (done_cyc < 0) begin
               done_cyc = c;
               f_cap = found; e_cap = err; r_cap = result; p_cap = probes;
            end
         end
         if (done_cyc >= 0 && c > done_cyc && busy) busy_after = 1'b1;
         if (pulse) start = (c == 2) || (c == 5) || done;
         else       start = 1'b0;
         if (done_cyc >= 0 && c >= done_cyc + 3) break;
      end
      start = 1'b0;
   endtask

   initial begin
      int packed_seq;
      rst = 1'b1; start = 1'b0; mode = 0; a_val = '0;

      vecs.push_back(mk(0, 8,  0, 1, 0, 1, 8,  1, 'h8,     1));
      vecs.push_back(mk(0, 11, 1, 1, 0, 4, 11, 1, 'h8CAB,  4));
      vecs.push_back(mk(0, 0,  0, 1, 0, 5, 0,  1, 'h84210, 5));
      vecs.push_back(mk(0, 1,  0, 1, 0, 4, 1,  0, 0, 0));
      vecs.push_back(mk(0, 2,  0, 1, 0, 3, 2,  0, 0, 0));
      vecs.push_back(mk(0, 3,  0, 1, 0, 4, 3,  0, 0, 0));
      vecs.push_back(mk(0, 4,  0, 1, 0, 2, 4,  0, 0, 0));
      vecs.push_back(mk(0, 5,  0, 1, 0, 4, 5,  0, 0, 0));
      vecs.push_back(mk(0, 6,  0, 1, 0, 3, 6,  0, 0, 0));
      vecs.push_back(mk(0, 7,  0, 1, 0, 4, 7,  0, 0, 0));
      vecs.push_back(mk(0, 8,  0, 1, 0, 1, 8,  0, 0, 0));
      vecs.push_back(mk(0, 9,  0, 1, 0, 4, 9,  0, 0, 0));
      vecs.push_back(mk(0, 10, 0, 1, 0, 3, 10, 0, 0, 0));
      vecs.push_back(mk(0, 11, 0, 1, 0, 4, 11, 0, 0, 0));
      vecs.push_back(mk(0, 12, 0, 1, 0, 2, 12, 0, 0, 0));
      vecs.push_back(mk(0, 13, 0, 1, 0, 4, 13, 0, 0, 0));
      vecs.push_back(mk(0, 14, 0, 1, 0, 3, 14, 0, 0, 0));
      vecs.push_back(mk(0, 15, 0, 1, 0, 4, 15, 1, 'h8CEF,  4));
      vecs.push_back(mk(1, 3,  0, 0, 1, 1, 15, 1, 'h8,     1));
      vecs.push_back(mk(0, 5,  0, 1, 0, 4, 5,  0, 0, 0));
      vecs.push_back(mk(2, 9,  0, 0, 1, 4, 5,  1, 'h8CEF,  4));

      #1;
      chk("rst_b_out",  int'(b_out),  0);
      chk("rst_busy",   int'(busy),   0);
      chk("rst_done",   int'(done),   0);
      chk("rst_found",  int'(found),  0);
      chk("rst_result", int'(result), 0);
      chk("rst_err",    int'(err),    0);
      chk("rst_probes", int'(probes), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", int'(busy), 0);

      foreach (vecs[i]) begin
         mode = vecs[i].mode;
         a_val = vecs[i].a;
         do_search(vecs[i].pulse);
         chk($sformatf("v%0d_ndone", i),  n_done, 1);
         chk($sformatf("v%0d_found", i),  int'(f_cap), int'(vecs[i].exp_found));
         chk($sformatf("v%0d_err", i),    int'(e_cap), int'(vecs[i].exp_err));
         chk($sformatf("v%0d_result", i), int'(r_cap), int'(vecs[i].exp_result));
         chk($sformatf("v%0d_probes", i), int'(p_cap), vecs[i].exp_probes);
         // each probe is SETTLE+1 = 3 cycles; done follows in the next one
         chk($sformatf("v%0d_donecyc", i), done_cyc, 3 * vecs[i].exp_probes + 1);
         chk($sformatf("v%0d_busy_after", i), int'(busy_after), 0);
         if (vecs[i].chk_seq) begin
            packed_seq = 0;
            foreach (seq_q[k]) packed_seq = (packed_seq << 4) | seq_q[k];
            chk($sformatf("v%0d_seqlen", i), seq_q.size(), vecs[i].exp_len);
            chk($sformatf("v%0d_seq", i), packed_seq, vecs[i].exp_seq);
         end
      end

      // Reset during the settle wait of the second probe of A=11.
      mode = 0; a_val = 4'd11;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_busy",  int'(busy),  1);
      chk("mid_b_out", int'(b_out), 12);
      chk("mid_probes", int'(probes), 1);
      rst = 1'b1;
      #1;
      chk("abort_b_out",  int'(b_out),  0);
      chk("abort_busy",   int'(busy),   0);
      chk("abort_done",   int'(done),   0);
      chk("abort_found",  int'(found),  0);
      chk("abort_result", int'(result), 0);
      chk("abort_err",    int'(err),    0);
      chk("abort_probes", int'(probes), 0);
      n_done = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) n_done++;
      end
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done) n_done++;
      end
      chk("abort_no_done", n_done, 0);
      chk("abort_idle", int'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
